arb_mux_nbit: RTL
=================

# arb_mux_nbit

Registered, arbitrated M-channel by N-bit multiplexer; the next-generation successor of the team's combinational Nbit muxes. Instead of an external select, it picks among M valid/ready input channels using round-robin or fixed-priority arbitration. Multi-word transfers are held together by a lock that lasts until `in_last`. It sits between producers sharing one datapath port (e.g. register-file write-back sources, memory request sources) and a single N-bit consumer, and provides one output register stage.

## Interface
- `N`, 64, data width in bits
- `M`, 4, number of input channels (2..8)
- `SW`, 2, select width; must equal clog2(M)
- `MODE`, 1, arbitration: 0 = fixed priority (channel 0 highest), 1 = round-robin

- `clk`  input  1  clock; all state updates on rising edge
- `reset`  input  1  synchronous, active-high reset
- `in_valid`  input  M  channel i presents a word
- `in_data`  input  M*N  channel i data at bits [i*N +: N]
- `in_last`  input  M  channel i word is the final word of its packet
- `in_ready`  output  M  channel i word accepted this cycle when `in_valid[i]` is also high
- `out_valid`  output  1  output register holds a word
- `out_data`  output  N  registered data
- `out_sel`  output  SW  channel index the held word came from
- `out_last`  output  1  registered copy of the source's `in_last`
- `out_ready`  input  1  consumer takes the word this cycle

## Operation
- The output register is either empty or full. `load_en = !out_valid | out_ready`.
- Grant (one-hot, combinational):
  - If locked, the grant is the lock channel whenever its `in_valid` is high. Otherwise there is no grant; other channels are never granted while locked.
  - If unlocked with MODE=1, the grant is the first channel with `in_valid` high, searching `ptr`, `ptr+1`, … with wrap modulo M.
  - If unlocked with MODE=0, the grant is the lowest-index channel with `in_valid` high.
- `in_ready[i] = grant[i] & load_en & !reset`. At most one bit is high per cycle.
- On transfer (`in_valid[g] & in_ready[g]`):
  - Load `out_data` with channel g's data, `out_sel` with g, and `out_last` with `in_last[g]`; set `out_valid`.
  - If `in_last[g]` is 0, lock to g.
  - If `in_last[g]` is 1, clear the lock and set `ptr` to (g+1) mod M. `ptr` is unused in MODE=0.
- If `out_valid & out_ready` and there is no transfer, clear `out_valid`. `out_data`, `out_sel` and `out_last` keep their values.
- The lock persists across idle cycles of the locked channel. Only `in_last` or reset releases it.
- Single-word packets (`in_last` = 1) never lock.

## Timing
- Reset values: `out_valid` 0, `out_data` 0, `out_sel` 0, `out_last` 0, `ptr` 0, lock clear.
- `in_ready` is all zeros while `reset` is high.
- Latency: a word accepted in cycle t appears with `out_valid` = 1 in cycle t+1.
- Throughput: one word per cycle while `out_ready` is held high.
- Backpressure: while `out_valid & !out_ready`, `out_data`, `out_sel` and `out_last` are held stable and `in_ready` is all zeros.
- Simultaneous drain and load in the same cycle: the new word replaces the old with no bubble, and `out_valid` stays 1.
- `in_ready` depends combinationally on `out_ready`, `in_valid` and state. There is no combinational path from `in_data` to any output.
- Reset mid-packet: the lock, `ptr` and the output register are cleared. The partial packet is discarded; the consumer sees `out_valid` = 0 on the next cycle.
- `ptr` wrap: when g = M-1, `ptr` becomes 0.

## Test plan
- Reset, then `in_valid` = 0 -> `out_valid` = 0, `out_data` = 0, `out_sel` = 0, `in_ready` = 0 for 10 cycles.
- MODE=1, M=4, all channels valid with `in_last` = 1 and data = 0x10+i, `out_ready` = 1 -> `out_sel` sequence 0,1,2,3,0 starting the cycle after the first accept, with `out_data` matching each source.
- MODE=1: channel 2 sends a 3-word packet (last on word 3) while channels 0 and 1 stay valid, and channel 2 drops valid for 2 cycles mid-packet -> no grant to 0 or 1 until channel 2's last word. Then `out_sel` = 3 if channel 3 is valid, else wraps to 0.
- Backpressure: `out_ready` = 0 for 5 cycles with a word held (data 0xDEADBEEF) -> `out_data` stable, `in_ready` all 0. Raising `out_ready` with a new word pending -> next word loads in the same cycle with no bubble.
- MODE=0: channels 1 and 3 continuously valid with `in_last` = 1 -> every accepted word has `out_sel` = 1, and channel 3 is never granted.
- Reset asserted during channel 1's locked packet -> the next cycle shows `out_valid` = 0 and the lock is clear. After reset, channel 0 (valid) is granted first in MODE=1.

Source files
------------

// File: rtl/arb_mux_nbit_if.sv
// rtl/arb_mux_nbit_if.sv - channel-side and consumer-side handshake bundle for arb_mux_nbit
interface arb_mux_nbit_if #(
  parameter int N  = 64,
  parameter int M  = 4,
  parameter int SW = 2
);
  logic [M-1:0]   in_valid;
  logic [M*N-1:0] in_data;
  logic [M-1:0]   in_last;
  logic [M-1:0]   in_ready;
  logic           out_valid;
  logic [N-1:0]   out_data;
  logic [SW-1:0]  out_sel;
  logic           out_last;
  logic           out_ready;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_sel, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_sel, out_last
  );
endinterface

// File: rtl/arb_mux_nbit.sv
// rtl/arb_mux_nbit.sv - registered M-channel arbitrated mux with packet lock
module arb_mux_nbit #(
  parameter int N    = 64,
  parameter int M    = 4,
  parameter int SW   = 2,
  parameter int MODE = 1
) (
  input  logic          clk,
  input  logic          reset,
  arb_mux_nbit_if.slave bus
);

  typedef enum logic {
    ST_OPEN,
    ST_LOCKED
  } lock_state_e;

  lock_state_e   state_q, state_d;
  logic [SW-1:0] lock_ch_q, lock_ch_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic          out_valid_q, out_valid_d;
  logic [N-1:0]  out_data_q, out_data_d;
  logic [SW-1:0] out_sel_q, out_sel_d;
  logic          out_last_q, out_last_d;

  logic          load_en;
  logic          xfer;
  logic          gnt_any;
  logic          gnt_last;
  logic [SW-1:0] gnt_idx;
  logic [M-1:0]  grant;
  logic [M-1:0]  rr_mask;
  logic [M-1:0]  req_hi;
  logic [N-1:0]  gnt_data;

  // Round-robin: prefer requesters at or above ptr, else wrap to the lowest index.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    rr_mask = '0;
    for (int i = 0; i < M; i++) begin
      rr_mask[i] = (SW'(i) >= ptr_q);
    end
    req_hi = bus.in_valid & rr_mask;
    if (state_q == ST_LOCKED) begin
      gnt_any = bus.in_valid[lock_ch_q];
      gnt_idx = lock_ch_q;
    end else if (MODE == 1 && |req_hi) begin
      gnt_any = 1'b1;
      for (int i = M - 1; i >= 0; i--) begin
        if (req_hi[i]) gnt_idx = SW'(i);
      end
    end else begin
      gnt_any = |bus.in_valid;
      for (int i = M - 1; i >= 0; i--) begin
        if (bus.in_valid[i]) gnt_idx = SW'(i);
      end
    end
  end

  always_comb begin
    grant    = '0;
    gnt_data = '0;
    gnt_last = 1'b0;
    for (int i = 0; i < M; i++) begin
      if (gnt_any && gnt_idx == SW'(i)) begin
        grant[i] = 1'b1;
        gnt_data = bus.in_data[i*N +: N];
        gnt_last = bus.in_last[i];
      end
    end
  end

  assign load_en      = !out_valid_q | bus.out_ready;
  assign xfer         = gnt_any & load_en & !reset;
  assign bus.in_ready = grant & {M{load_en & !reset}};

  always_comb begin
    state_d     = state_q;
    lock_ch_d   = lock_ch_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_last_d  = out_last_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = gnt_data;
      out_sel_d   = gnt_idx;
      out_last_d  = gnt_last;
      if (gnt_last) begin
        state_d = ST_OPEN;
        ptr_d   = (gnt_idx == SW'(M - 1)) ? '0 : gnt_idx + 1'b1;
      end else begin
        state_d   = ST_LOCKED;
        lock_ch_d = gnt_idx;
      end
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_OPEN;
      lock_ch_q   <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_ch_q   <= lock_ch_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_last_q  <= out_last_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_last  = out_last_q;

endmodule
